// File: rtl/hub_repeater_core.sv
// hub_repeater_core: repeats the single active port to all others, jams on collision, with jabber and auto-partition.
module hub_repeater_core #(
  parameter int         PORT_COUNT      = 4,
  parameter int         PARTITION_LIMIT = 31,
  parameter int         CLEAN_LEN       = 128,
  parameter int         JABBER_LIMIT    = 12500,
  parameter logic [3:0] JAM_NIBBLE      = 4'h5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [PORT_COUNT-1:0]   port_enable,
  input  logic [PORT_COUNT-1:0]   rx_dv,
  input  logic [PORT_COUNT-1:0]   rx_er,
  input  logic [4*PORT_COUNT-1:0] rxd,
  output logic [PORT_COUNT-1:0]   tx_en,
  output logic [PORT_COUNT-1:0]   tx_er,
  output logic [4*PORT_COUNT-1:0] txd,
  output logic                    jam,
  output logic                    activity,
  output logic [PORT_COUNT-1:0]   partitioned,
  output logic [PORT_COUNT-1:0]   jabber
);
  localparam int LMAX = CLEAN_LEN > JABBER_LIMIT ? CLEAN_LEN : JABBER_LIMIT;
  localparam int LW   = $clog2(LMAX + 1);
  localparam int CW   = $clog2(PARTITION_LIMIT + 1);
  localparam int PCW  = $clog2(PORT_COUNT + 1);

  logic [LW-1:0]         len  [PORT_COUNT];
  logic [CW-1:0]         ccnt [PORT_COUNT];
  logic [PORT_COUNT-1:0] col, carrier, rep;
  logic [PCW-1:0]        n_car, n_rep;
  logic [3:0]            src_d;
  logic                  src_er, single, multi;

  always_comb begin
    carrier = rx_dv & port_enable & ~jabber;
    rep     = carrier & ~partitioned;
    n_car   = '0;
    n_rep   = '0;
    src_d   = '0;
    src_er  = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      n_car = n_car + PCW'(carrier[i]);
      n_rep = n_rep + PCW'(rep[i]);
      src_d  = rep[i] ? rxd[4*i +: 4] : src_d;
      src_er = rep[i] ? rx_er[i] : src_er;
    end
    single = n_rep == PCW'(1);
    multi  = n_rep >= PCW'(2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en    <= '0;
      tx_er    <= '0;
      txd      <= '0;
      jam      <= 1'b0;
      activity <= 1'b0;
    end else if (ce) begin
      jam      <= multi;
      activity <= single | multi;
      for (int i = 0; i < PORT_COUNT; i++) begin
        tx_en[i]       <= multi | (single & ~rep[i]);
        tx_er[i]       <= single & ~rep[i] & src_er;
        txd[4*i +: 4]  <= multi ? JAM_NIBBLE : (single & ~rep[i]) ? src_d : 4'h0;
      end
    end
  end

  // len != 0 marks an event in progress; a jabber trip discards the event outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      partitioned <= '0;
      jabber      <= '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
        len[i]  <= '0;
        ccnt[i] <= '0;
      end
    end else if (ce) begin
      for (int i = 0; i < PORT_COUNT; i++) begin
        if (!port_enable[i]) begin
          len[i]         <= '0;
          col[i]         <= 1'b0;
          ccnt[i]        <= '0;
          partitioned[i] <= 1'b0;
          jabber[i]      <= 1'b0;
        end else if (jabber[i]) begin
          jabber[i] <= rx_dv[i];
        end else if (rx_dv[i]) begin
          if (len[i] >= LW'(JABBER_LIMIT - 1)) begin
            jabber[i] <= 1'b1;
            len[i]    <= '0;
            col[i]    <= 1'b0;
          end else begin
            len[i] <= len[i] == LW'(LMAX) ? len[i] : len[i] + LW'(1);
            col[i] <= col[i] | (n_car >= PCW'(2));
          end
        end else if (len[i] != '0) begin
          len[i] <= '0;
          col[i] <= 1'b0;
          if (col[i]) begin
            ccnt[i] <= ccnt[i] == CW'(PARTITION_LIMIT) ? ccnt[i] : ccnt[i] + CW'(1);
            if (ccnt[i] >= CW'(PARTITION_LIMIT - 1))
              partitioned[i] <= 1'b1;
          end else if (len[i] >= LW'(CLEAN_LEN)) begin
            ccnt[i]        <= '0;
            partitioned[i] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hub_repeater_core.sv
// tb_hub_repeater_core: directed checks of repeat, jam, partition, jabber, disable and async reset.
module tb_hub_repeater_core;
  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic [3:0]  port_enable = 4'hF, rx_dv = '0, rx_er = '0;
  logic [15:0] rxd = '0;
  logic [3:0]  tx_en, tx_er, partitioned, jabber;
  logic [15:0] txd;
  logic        jam, activity;
  int          errors = 0, checks = 0;

  hub_repeater_core dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .port_enable(port_enable),
    .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .tx_en(tx_en), .tx_er(tx_er), .txd(txd), .jam(jam), .activity(activity),
    .partitioned(partitioned), .jabber(jabber)
  );

  always #4 clk = ~clk;

  task automatic tick();
    @(negedge clk) ce = 1'b1;
    @(negedge clk) ce = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // drive a lone frame of n nibbles on port p, then one idle ce
  task automatic frame(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      rx_dv = 4'b0001 << p;
      tick();
    end
    rx_dv = '0;
    tick();
  endtask

  initial begin
    int bad;
    logic [3:0] n;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_jam", jam, 0);
    chk("rst_activity", activity, 0);
    chk("rst_part", partitioned, 0);
    chk("rst_jab", jabber, 0);
    rst_n = 1'b1;
    tick();
    // single source on port 1
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      n = 4'(k);
      rx_dv = 4'b0010;
      rxd = {8'h00, n, 4'h0};
      rx_er = (k == 10) ? 4'b0010 : 4'b0000;
      tick();
      if (tx_en !== 4'b1101 || txd !== {n, n, 4'h0, n} || activity !== 1'b1 || jam !== 1'b0) bad++;
      if (k == 10) chk("single_tx_er_pulse", tx_er, 4'b1101);
      if (k == 11) chk("single_tx_er_clear", tx_er, 4'b0000);
    end
    chk("single_repeat_bad", bad, 0);
    chk("single_txd_last", txd, 16'hFF0F);
    rx_dv = '0; rx_er = '0;
    tick();
    chk("idle_tx_en", tx_en, 0);
    chk("idle_activity", activity, 0);
    chk("idle_txd", txd, 0);
    // collision ports 0 and 2
    bad = 0;
    rxd = 16'h0903;
    for (int k = 0; k < 20; k++) begin
      rx_dv = 4'b0101;
      tick();
      if (tx_en !== 4'hF || txd !== 16'h5555 || jam !== 1'b1 || tx_er !== 4'h0 || activity !== 1'b1) bad++;
    end
    chk("col_jam_bad", bad, 0);
    rx_dv = '0;
    tick();
    chk("col_end_jam", jam, 0);
    chk("col_end_part", partitioned, 0);
    // clean frame on port 0 reconnects (ccnt back to 0)
    frame(0, 128);
    chk("clean_part", partitioned, 0);
    // 31 collisions ports 0 and 3
    for (int c = 0; c < 31; c++) begin
      for (int k = 0; k < 20; k++) begin
        rx_dv = 4'b1001;
        tick();
      end
      rx_dv = '0;
      tick();
      if (c == 29) chk("part_after30", partitioned, 4'b0000);
    end
    chk("part_after31", partitioned, 4'b1001);
    rx_dv = 4'b0001;
    tick();
    chk("part_src_tx_en", tx_en, 0);
    chk("part_src_activity", activity, 0);
    rx_dv = '0;
    tick();
    frame(0, 127);
    chk("part_127", partitioned, 4'b1001);
    frame(0, 128);
    chk("part_128", partitioned, 4'b1000);
    // a partitioned port still receives
    rx_dv = 4'b0010; rxd = 16'h00A0;
    tick();
    chk("part_rx_tx_en", tx_en, 4'b1101);
    chk("part_rx_txd", txd, 16'hAA0A);
    rx_dv = '0;
    tick();
    // jabber on port 2
    bad = 0;
    rxd = 16'h0700;
    for (int k = 1; k <= 12500; k++) begin
      rx_dv = 4'b0100;
      tick();
      if (tx_en !== 4'b1011 || txd !== 16'h7077) bad++;
      if (k == 12499) chk("jab_before", jabber, 4'b0000);
    end
    chk("jab_repeat_bad", bad, 0);
    chk("jab_trip", jabber, 4'b0100);
    tick();
    chk("jab_tx_en", tx_en, 0);
    chk("jab_activity", activity, 0);
    repeat (4) tick();
    chk("jab_hold", jabber, 4'b0100);
    rx_dv = '0;
    tick();
    chk("jab_clear", jabber, 0);
    chk("jab_part", partitioned, 4'b1000);
    // port disable mid-frame
    rx_dv = 4'b0010; rxd = 16'h0030;
    repeat (5) tick();
    chk("dis_before", tx_en, 4'b1101);
    port_enable = 4'b1101;
    tick();
    chk("dis_stop", tx_en, 0);
    rx_dv = 4'b0110; rxd = 16'h0B30;
    tick();
    chk("dis_rx_tx_en", tx_en, 4'b1011);
    chk("dis_rx_jam", jam, 0);
    chk("dis_rx_txd", txd, 16'hB0BB);
    rx_dv = '0;
    tick();
    chk("dis_flags", {partitioned[1], jabber[1]}, 0);
    // async reset mid-jam
    port_enable = 4'hF;
    rx_dv = 4'b0110;
    tick();
    chk("pre_rst_jam", jam, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx_en", tx_en, 0);
    chk("arst_jam", jam, 0);
    chk("arst_activity", activity, 0);
    chk("arst_part", partitioned, 0);
    chk("arst_jab", jabber, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_jam", jam, 1);
    chk("post_rst_tx_en", tx_en, 4'hF);
    rx_dv = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
